// File: rtl/core_seq_pkg.sv
// rtl/core_seq_pkg.sv - shared types and constants for the attention-core instruction sequencer
//
// Holds the sequencer state enum, the inst bus field positions and the job
// geometry constants. The RDBK state exists only when CORE_SEQ_READBACK_EN
// is defined.
package core_seq_pkg;

  localparam int INST_W     = 19;
  localparam int ADDR_W     = 4;
  localparam int CNT_W      = 5;   // holds 0..16 (n and col+1 phase lengths)

  localparam int COL        = 8;   // MAC array columns = K vectors loaded
  localparam int KLOAD_GAP  = 2;   // settle cycles between K load and execute
  localparam int N_MAX      = 16;  // max Q rows = SRAM depth

  // inst bus bit positions
  localparam int DIV_B      = 18;
  localparam int ACC_B      = 17;
  localparam int OFIFO_RD_B = 16;
  localparam int QK_ADD_LSB = 12;
  localparam int P_ADD_LSB  = 8;
  localparam int EXEC_B     = 7;
  localparam int KLOAD_B    = 6;
  localparam int QMEM_RD_B  = 5;
  localparam int QMEM_WR_B  = 4;
  localparam int KMEM_RD_B  = 3;
  localparam int KMEM_WR_B  = 2;
  localparam int PMEM_RD_B  = 1;
  localparam int PMEM_WR_B  = 0;

  typedef enum logic [3:0] {
    S_IDLE,
    S_QWR,
    S_KWR,
    S_KLOAD,
    S_GAP,
    S_EXEC,
    S_WAITV,
    S_ACC,
    S_DIV,
`ifdef CORE_SEQ_READBACK_EN
    S_RDBK,
`endif
    S_DONE
  } state_t;

endpackage

// File: rtl/core_seq_cnt.sv
// rtl/core_seq_cnt.sv - loadable saturating down-counter with terminal-count flag
//
// Ports:
//   clk, reset (async, active-low)
//   load, load_val : load takes priority over counting
//   en             : decrement by one while non-zero (never wraps)
//   cnt, tc        : current value, tc high when cnt == 0
module core_seq_cnt #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic         tc
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - W'(1);
    end
  end

  assign tc = (cnt == '0);

endmodule

// File: rtl/core_seq.sv
// rtl/core_seq.sv - instruction sequencer driving the attention core inst bus for one job
//
// Optional feature macro: CORE_SEQ_READBACK_EN (adds the psum readback phase).
//
// Ports:
//   clk, reset (async, active-low)
//   start      : one-cycle pulse, accepted only when idle and not in the done cycle
//   n_rows     : Q rows for the job (saturates to 16), sampled on accepted start
//   fifo_valid : core output FIFO has a vector ready
//   inst       : 19-bit core instruction bus
//   data_req   : host must drive mem_in for data_addr this cycle
//   data_addr  : address of the requested mem_in vector
//   busy, done : job in progress / one-cycle end-of-job pulse
//
// Every output is a flop loaded from a decode of the current state, so the
// bus shows each state cycle one clock after the FSM is in it.
module core_seq
  import core_seq_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [4:0]        n_rows,
  input  logic              fifo_valid,
  output logic [INST_W-1:0] inst,
  output logic              data_req,
  output logic [ADDR_W-1:0] data_addr,
  output logic              busy,
  output logic              done
);

  state_t             state, state_nx;
  logic [CNT_W-1:0]   n_q;
  logic [CNT_W-1:0]   n_sat;
  logic               accept;

  logic               ph_load;
  logic [CNT_W-1:0]   ph_val;
  logic [CNT_W-1:0]   ph_cnt;
  logic               ph_tc;

  logic               r_load;
  logic [CNT_W-1:0]   r_val;
  logic               r_en;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_tc;

  logic [INST_W-1:0]  inst_nx;
  logic               req_nx;
  logic [ADDR_W-1:0]  addr_nx;
  logic               busy_nx;
  logic               done_nx;
  logic [ADDR_W-1:0]  qk_add;
  logic [ADDR_W-1:0]  p_add;

  assign n_sat  = (n_rows > CNT_W'(N_MAX)) ? CNT_W'(N_MAX) : n_rows;
  // done is still high in the IDLE cycle after DONE; a start there is dropped
  assign accept = start && (state == S_IDLE) && !done;

  // Phase length counter: loaded with (cycles-1) on state entry, exit on tc.
  core_seq_cnt #(.W(CNT_W)) u_phase_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (ph_load),
    .load_val (ph_val),
    .en       (1'b1),
    .cnt      (ph_cnt),
    .tc       (ph_tc)
  );

  // Remaining-rows counter for the WAITV/ACC/DIV drain loop.
  core_seq_cnt #(.W(CNT_W)) u_row_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (r_load),
    .load_val (r_val),
    .en       (r_en),
    .cnt      (r_cnt),
    .tc       (r_tc)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
      n_q   <= '0;
    end else begin
      state <= state_nx;
      if (accept) n_q <= n_sat;
    end
  end

  always_comb begin
    state_nx = state;
    ph_load  = 1'b0;
    ph_val   = '0;
    r_load   = 1'b0;
    r_val    = '0;
    r_en     = 1'b0;
    case (state)
      S_IDLE: begin
        if (accept) begin
          if (n_sat == '0) begin
            state_nx = S_DONE;
          end else begin
            state_nx = S_QWR;
            ph_load  = 1'b1;
            ph_val   = n_sat - CNT_W'(1);
          end
        end
      end
      S_QWR: if (ph_tc) begin
        state_nx = S_KWR;
        ph_load  = 1'b1;
        ph_val   = CNT_W'(COL - 1);
      end
      S_KWR: if (ph_tc) begin
        state_nx = S_KLOAD;
        ph_load  = 1'b1;
        ph_val   = CNT_W'(COL);           // col+1 cycles
      end
      S_KLOAD: if (ph_tc) begin
        state_nx = S_GAP;
        ph_load  = 1'b1;
        ph_val   = CNT_W'(KLOAD_GAP - 1);
      end
      S_GAP: if (ph_tc) begin
        state_nx = S_EXEC;
        ph_load  = 1'b1;
        ph_val   = n_q;                   // n+1 cycles
      end
      S_EXEC: if (ph_tc) begin
        state_nx = S_WAITV;
        r_load   = 1'b1;
        r_val    = n_q - CNT_W'(1);
      end
      S_WAITV: if (fifo_valid) state_nx = S_ACC;
      S_ACC:   state_nx = S_DIV;
      S_DIV: begin
        if (!r_tc) begin
          r_en     = 1'b1;
          state_nx = S_WAITV;
        end else begin
`ifdef CORE_SEQ_READBACK_EN
          state_nx = S_RDBK;
          ph_load  = 1'b1;
          ph_val   = n_q - CNT_W'(1);
`else
          state_nx = S_DONE;
`endif
        end
      end
`ifdef CORE_SEQ_READBACK_EN
      S_RDBK: if (ph_tc) state_nx = S_DONE;
`endif
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Output decode. Indices run upward while the counters run down, so each
  // address is (phase length - 1 - count).
  always_comb begin
    inst_nx = '0;
    req_nx  = 1'b0;
    addr_nx = '0;
    done_nx = 1'b0;
    qk_add  = '0;
    p_add   = '0;
    busy_nx = accept || ((state != S_IDLE) && (state != S_DONE));
    case (state)
      S_QWR: begin
        qk_add             = ADDR_W'(n_q - CNT_W'(1) - ph_cnt);
        inst_nx[QMEM_WR_B] = 1'b1;
        req_nx             = 1'b1;
        addr_nx            = qk_add;
      end
      S_KWR: begin
        qk_add             = ADDR_W'(CNT_W'(COL - 1) - ph_cnt);
        inst_nx[KMEM_WR_B] = 1'b1;
        req_nx             = 1'b1;
        addr_nx            = qk_add;
      end
      S_KLOAD: begin
        // kernel-load trails the kmem read by one cycle (SRAM read latency)
        if (ph_cnt != '0) begin
          qk_add             = ADDR_W'(CNT_W'(COL) - ph_cnt);
          inst_nx[KMEM_RD_B] = 1'b1;
        end
        if (ph_cnt != CNT_W'(COL)) inst_nx[KLOAD_B] = 1'b1;
      end
      S_EXEC: begin
        if (ph_cnt != '0) begin
          qk_add             = ADDR_W'(n_q - ph_cnt);
          inst_nx[QMEM_RD_B] = 1'b1;
        end
        if (ph_cnt != n_q) inst_nx[EXEC_B] = 1'b1;
      end
      S_ACC: begin
        inst_nx[OFIFO_RD_B] = 1'b1;
        inst_nx[ACC_B]      = 1'b1;
      end
      S_DIV: begin
        p_add              = ADDR_W'(n_q - CNT_W'(1) - r_cnt);
        inst_nx[DIV_B]     = 1'b1;
        inst_nx[PMEM_WR_B] = 1'b1;
      end
`ifdef CORE_SEQ_READBACK_EN
      S_RDBK: begin
        p_add              = ADDR_W'(n_q - CNT_W'(1) - ph_cnt);
        inst_nx[PMEM_RD_B] = 1'b1;
      end
`endif
      S_DONE:  done_nx = 1'b1;
      default: ;
    endcase
    inst_nx[QK_ADD_LSB +: ADDR_W] = qk_add;
    inst_nx[P_ADD_LSB  +: ADDR_W] = p_add;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      inst      <= '0;
      data_req  <= 1'b0;
      data_addr <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      inst      <= inst_nx;
      data_req  <= req_nx;
      data_addr <= addr_nx;
      busy      <= busy_nx;
      done      <= done_nx;
    end
  end

endmodule

// File: doc/core_seq.md
Name: core_seq

Overview:
- Instruction sequencer: the initiator that drives the 19-bit inst bus of the attention core (the core is the responder).
- Runs one full job: Q/K SRAM fill, K weight load into the MAC array, Q execute, output-FIFO drain through the SFP (acc then div), and psum-mem write.
- Sits between the top-level testbench/host and the core.
- Also tells the host when to present each mem_in vector.

Parameters:
- col, 8, MAC array columns; number of K vectors loaded (K-load cycles).
- pr, 16, vector lanes; informational only, no logic depends on it.
- kload_gap, 2, idle cycles between K load and execute (array settle).
- n_max, 16, max Q rows; equals SRAM depth, so addresses are 4 bits.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low; 0 forces all state to reset values.
- start  in  1  one-cycle pulse; begins a job when idle.
- n_rows  in  5  Q vectors per job, 0..16; sampled on the accepted start.
- fifo_valid  in  1  ofifo o_valid from the core.
- inst  out  19  core instruction bus (field map below).
- data_req  out  1  host must drive mem_in for address data_addr this cycle.
- data_addr  out  4  address of the mem_in vector requested.
- busy  out  1  high from the accepted start until done.
- done  out  1  one-cycle pulse at job end.

Behaviour:
- inst field map:
  - [18] div, [17] acc, [16] ofifo_rd.
  - [15:12] qkmem_add, [11:8] pmem_add.
  - [7] execute, [6] kernel-load / kmem select.
  - [5] qmem_rd, [4] qmem_wr, [3] kmem_rd, [2] kmem_wr, [1] pmem_rd, [0] pmem_wr.
- Reset values: inst=0, data_req=0, data_addr=0, busy=0, done=0, state=IDLE, all counters 0.
- All outputs are registered.
- States:
  - IDLE: wait for start; latch n_rows into n.
    - n=0 goes straight to DONE.
    - Otherwise go to QWR.
  - QWR: n cycles; qmem_wr=1, qkmem_add=i, data_req=1, data_addr=i, for i=0..n-1. Then KWR.
  - KWR: col cycles; kmem_wr=1, qkmem_add=j, data_req=1, data_addr=j, for j=0..col-1. Then KLOAD.
  - KLOAD: col+1 cycles; kmem_rd=1 with qkmem_add=j on cycles 0..col-1; inst[6]=1 on cycles 1..col, one cycle behind the SRAM read latency. Then GAP.
  - GAP: kload_gap cycles; inst=0. Then EXEC.
  - EXEC: n+1 cycles; qmem_rd=1 with qkmem_add=i on cycles 0..n-1; inst[7]=1 on cycles 1..n. Then WAITV with r=0.
  - WAITV: inst=0 until fifo_valid=1. Then ACC.
  - ACC: 1 cycle; ofifo_rd=1, acc=1. Then DIV.
  - DIV: 1 cycle; div=1, pmem_wr=1, pmem_add=r.
    - r+1<n: increment r, go to WAITV.
    - Otherwise go to DONE (or RDBK when the optional feature is compiled in).
  - DONE: 1 cycle; done=1, busy falls in the same cycle. Then IDLE.
- busy rises the cycle after the accepted start.
- start while busy is ignored; start during the DONE cycle is also ignored.
- n_rows>16 saturates to 16.
- Counters wrap only by state exit; an address never exceeds n-1 or col-1.
- Reset asserted mid-job aborts immediately: inst goes to 0 asynchronously and no partial write completes.
- fifo_valid dropping during ACC/DIV is tolerated (already consumed); it is re-checked only in WAITV.
- No timeout: WAITV stalls indefinitely with inst=0.

Optional Feature:
- Macro: CORE_SEQ_READBACK_EN.
- Defined: DIV exits to RDBK instead of DONE. RDBK runs n cycles with pmem_rd=1, pmem_add=0..n-1, then goes to DONE.
- Not defined: no RDBK state, pmem_rd is tied 0, DIV goes directly to DONE.

Decomposition:
- Package core_seq_pkg holds:
  - state enum;
  - inst bit-position constants (DIV_B=18 .. PMEM_WR_B=0);
  - QK_ADD_LSB=12, P_ADD_LSB=8;
  - INST_W=19.
- One sub-module, core_seq_cnt: loadable down-counter with terminal-count flag. Instantiated for the phase length and the row index.

Test Plan:
- n_rows=4, start -> QWR qmem_wr at addresses 0..3 with data_req=1; KWR kmem_wr at 0..7; KLOAD 9 cycles with inst[6] high on cycles 1..8.
- n_rows=4, fifo_valid held 1 -> 4 ACC/DIV pairs, pmem_wr at pmem_add 0,1,2,3; done pulses once; total latency from start matches the state sum exactly.
- fifo_valid held 0 for 20 cycles in WAITV -> inst=0 throughout; resume when it is raised.
- n_rows=0 -> busy pulse, done 2 cycles after start, no memory strobes.
- start repeated mid-job -> ignored; reset driven 0 during EXEC -> inst=0, busy=0 immediately; a later start runs a clean job.
- CORE_SEQ_READBACK_EN, n_rows=3 -> pmem_rd at addresses 0..2 after the last DIV, then done.
